id_operand_stage: RTL and testbench
===================================

// Module: id_operand_stage
// PURPOSE
//   Parametrised decode/operand stage for the in-order pipeline. Holds the
//   IF->ID pipeline register and its valid/allowin handshake. Resolves each
//   source operand from the forwarding network (youngest stage first), else
//   from the regfile. Stalls only when the matching producer's data is not yet
//   available. Supersedes plain stall-on-any-RAW interlocking.
// PARAMETERS
//   DATA_W     32  operand / register data width
//   RADDR_W     5  register address width; address 0 is hard-wired zero
//   NSRC        2  source operands per instruction
//   NFWD        3  forwarding sources; index 0 = youngest (EXE), NFWD-1 = oldest (WB)
//   PAYLOAD_W  64  IF->ID bus width ({inst, pc})
//   CNT_W      32  stall performance counter width
// PORTS
//   clk          in   1               clock, all state on rising edge
//   resetn       in   1               asynchronous, active-low reset
//   in_valid     in   1               upstream holds a valid instruction
//   in_allowin   out  1               stage accepts a new instruction this cycle
//   in_payload   in   PAYLOAD_W       upstream bus, captured on handshake
//   flush        in   1               branch cancel: drop the held instruction
//   id_payload   out  PAYLOAD_W       held payload, routed to the external decoder
//   id_raddr     in   NSRC*RADDR_W    decoded source addresses (src s at [s*RADDR_W +: RADDR_W])
//   id_ruse      in   NSRC            source s is actually read by the instruction
//   rf_rdata     in   NSRC*DATA_W     regfile read data for id_raddr
//   fwd_valid    in   NFWD            forwarding source holds a valid instruction
//   fwd_we       in   NFWD            that instruction writes the regfile
//   fwd_waddr    in   NFWD*RADDR_W    its destination
//   fwd_ready    in   NFWD            its result is available (0: load in EXE, busy multi-cycle op)
//   fwd_wdata    in   NFWD*DATA_W     its result, meaningful when fwd_ready=1
//   id_operand   out  NSRC*DATA_W     resolved operands
//   id_ready_go  out  1               no operand is stalled
//   out_valid    out  1               id_valid && id_ready_go
//   out_allowin  in   1               downstream (EXE) accepts
//   stall_cnt    out  CNT_W           cycles spent stalled, saturating
// BEHAVIOUR
//   Reset: id_valid=0, id_payload=0, stall_cnt=0. So out_valid=0 and in_allowin=1.
//   in_allowin = !id_valid || (id_ready_go && out_allowin). This is combinational.
//   Handshake in_valid && in_allowin loads in_payload. The payload register is
//     otherwise unchanged.
//   id_valid next state, in priority order:
//     1. flush: 0. Also drops any instruction handshaking in the same cycle.
//     2. in_allowin: in_valid.
//     3. otherwise: hold.
//   Per source s (combinational, zero latency):
//     - !id_ruse[s] or raddr==0: operand=0 when raddr==0, else rf_rdata; never stalls.
//     - Match f: fwd_valid[f] && fwd_we[f] && fwd_waddr[f]==raddr.
//       The lowest matching f wins.
//     - Match with fwd_ready[f]=1: operand = fwd_wdata[f].
//     - Match with fwd_ready[f]=0: source stalls. An older ready match does NOT
//       satisfy the source, because it holds stale data.
//     - No match: operand = rf_rdata[s].
//   id_ready_go = no source stalls. When !id_valid it is don't-care, driven 1.
//   The stage holds its instruction while id_valid && !(id_ready_go && out_allowin).
//   stall_cnt: +1 each cycle with id_valid && !id_ready_go && !flush.
//     Saturates at all-ones.
//   Asynchronous reset mid-stall clears id_valid immediately. No operand state is
//     retained, because operands are recomputed every cycle.
// TESTING
//   1. Reset asserted: out_valid=0, in_allowin=1, stall_cnt=0. Release, send
//      add r3,r1,r2 with no matches -> operands = rf_rdata, out_valid the next cycle.
//   2. EXE (f0) writes r1=0x11, ready; WB (f2) writes r1=0x22
//      -> operand0=0x11 (youngest wins), no stall.
//   3. Load to r4 in EXE, fwd_ready0=0; consumer reads r4 -> 1 stall cycle,
//      stall_cnt=1. Next cycle MEM match ready=1 -> operand = MEM data, out_valid=1.
//   4. Source r0 with a producer writing r0=0xFF -> operand=0, no stall.
//   5. flush together with in_valid=1 -> id_valid=0 the next cycle, payload ignored.
//      A flush during a stall -> instruction dropped, stall_cnt stops.
//   6. out_allowin=0 for 3 cycles with a valid instruction -> in_allowin=0,
//      id_payload stable; stall_cnt unchanged (not a RAW stall).

Source files
------------

// File: rtl/id_operand_stage.sv
// ---------------------------------------------------------------------------
// id_operand_stage
//   Decode/operand stage of the in-order pipeline. It holds the IF->ID
//   pipeline register and the valid/allowin handshake on both sides. It also
//   resolves every source operand from the forwarding network, checking the
//   youngest producer first and falling back to the regfile. The stage stalls
//   only when the youngest matching producer has not produced its result yet.
//
// Handshake: a transfer happens on a rising edge where valid && allowin.
//   The sender holds its payload until then. The receiver may compute allowin
//   combinationally from its own state and its downstream allowin.
//
// Ports
//   clk, resetn   clock; asynchronous active-low reset
//   in_valid      upstream offers an instruction
//   in_allowin    stage can take an instruction this cycle
//   in_payload    upstream {inst, pc}, captured on the handshake
//   flush         branch cancel: drop the held instruction and any incoming one
//   id_payload    held payload, sent to the external decoder
//   id_raddr      decoded source addresses, src s at [s*RADDR_W +: RADDR_W]
//   id_ruse       source s is actually read
//   rf_rdata      regfile read data for id_raddr
//   fwd_valid/we/waddr/ready/wdata
//                 forwarding sources; index 0 = youngest (EXE)
//   id_operand    resolved operands
//   id_ready_go   no source is stalled (1 when the stage is empty)
//   out_valid     instruction ready to move to EXE
//   out_allowin   EXE accepts
//   stall_cnt     saturating count of RAW-stall cycles
// ---------------------------------------------------------------------------
module id_operand_stage #(
    parameter int DATA_W    = 32,
    parameter int RADDR_W   = 5,
    parameter int NSRC      = 2,
    parameter int NFWD      = 3,
    parameter int PAYLOAD_W = 64,
    parameter int CNT_W     = 32
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     in_valid,
    output logic                     in_allowin,
    input  logic [PAYLOAD_W-1:0]     in_payload,
    input  logic                     flush,
    output logic [PAYLOAD_W-1:0]     id_payload,
    input  logic [NSRC*RADDR_W-1:0]  id_raddr,
    input  logic [NSRC-1:0]          id_ruse,
    input  logic [NSRC*DATA_W-1:0]   rf_rdata,
    input  logic [NFWD-1:0]          fwd_valid,
    input  logic [NFWD-1:0]          fwd_we,
    input  logic [NFWD*RADDR_W-1:0]  fwd_waddr,
    input  logic [NFWD-1:0]          fwd_ready,
    input  logic [NFWD*DATA_W-1:0]   fwd_wdata,
    output logic [NSRC*DATA_W-1:0]   id_operand,
    output logic                     id_ready_go,
    output logic                     out_valid,
    input  logic                     out_allowin,
    output logic [CNT_W-1:0]         stall_cnt
);

    logic                     r_id_valid;
    logic [PAYLOAD_W-1:0]     r_id_payload;
    logic [CNT_W-1:0]         r_stall_cnt;

    logic [NSRC*DATA_W-1:0]   w_operand;
    logic [NSRC-1:0]          w_src_stall;
    logic [RADDR_W-1:0]       w_raddr;
    logic                     w_hit;
    logic                     w_hit_ready;
    logic [DATA_W-1:0]        w_hit_data;
    logic                     w_ready_go;
    logic                     w_allowin;
    logic                     w_stall_event;

    // Operand resolution. The forwarding sources are scanned from oldest to
    // youngest, so the youngest match overwrites older ones. An older ready
    // match must never cover a younger pending producer, because its data
    // is stale.
    always_comb begin
        w_operand   = '0;
        w_src_stall = '0;
        w_raddr     = '0;
        w_hit       = 1'b0;
        w_hit_ready = 1'b0;
        w_hit_data  = '0;
        for (int s = 0; s < NSRC; s++) begin
            w_raddr     = id_raddr[s*RADDR_W +: RADDR_W];
            w_hit       = 1'b0;
            w_hit_ready = 1'b0;
            w_hit_data  = '0;
            for (int f = NFWD - 1; f >= 0; f--) begin
                if (fwd_valid[f] && fwd_we[f] &&
                    (fwd_waddr[f*RADDR_W +: RADDR_W] == w_raddr)) begin
                    w_hit       = 1'b1;
                    w_hit_ready = fwd_ready[f];
                    w_hit_data  = fwd_wdata[f*DATA_W +: DATA_W];
                end
            end
            if (w_raddr == '0) begin
                // r0 is hard-wired zero, even if a producer claims to write it
                w_operand[s*DATA_W +: DATA_W] = '0;
            end else if (!id_ruse[s] || !w_hit) begin
                w_operand[s*DATA_W +: DATA_W] = rf_rdata[s*DATA_W +: DATA_W];
            end else begin
                w_operand[s*DATA_W +: DATA_W] = w_hit_data;
                w_src_stall[s]                = !w_hit_ready;
            end
        end
    end

    assign w_ready_go    = !r_id_valid || (w_src_stall == '0);
    assign w_allowin     = !r_id_valid || (w_ready_go && out_allowin);
    // Only RAW stalls count; back-pressure from EXE does not.
    assign w_stall_event = r_id_valid && !w_ready_go && !flush;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_id_valid   <= 1'b0;
            r_id_payload <= '0;
            r_stall_cnt  <= '0;
        end else begin
            if (in_valid && w_allowin) begin
                r_id_payload <= in_payload;
            end
            if (flush) begin
                r_id_valid <= 1'b0;
            end else if (w_allowin) begin
                r_id_valid <= in_valid;
            end
            if (w_stall_event && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign in_allowin  = w_allowin;
    assign id_payload  = r_id_payload;
    assign id_operand  = w_operand;
    assign id_ready_go = w_ready_go;
    assign out_valid   = r_id_valid && w_ready_go;
    assign stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_id_operand_stage.sv
// Directed bench for id_operand_stage. The stall counter is narrowed to 3 bits
// so that its saturation point can be reached in a few cycles.
module tb_id_operand_stage;

    localparam int DATA_W    = 32;
    localparam int RADDR_W   = 5;
    localparam int NSRC      = 2;
    localparam int NFWD      = 3;
    localparam int PAYLOAD_W = 64;
    localparam int CNT_W     = 3;

    logic                     clk;
    logic                     resetn;
    logic                     in_valid;
    logic                     in_allowin;
    logic [PAYLOAD_W-1:0]     in_payload;
    logic                     flush;
    logic [PAYLOAD_W-1:0]     id_payload;
    logic [NSRC*RADDR_W-1:0]  id_raddr;
    logic [NSRC-1:0]          id_ruse;
    logic [NSRC*DATA_W-1:0]   rf_rdata;
    logic [NFWD-1:0]          fwd_valid;
    logic [NFWD-1:0]          fwd_we;
    logic [NFWD*RADDR_W-1:0]  fwd_waddr;
    logic [NFWD-1:0]          fwd_ready;
    logic [NFWD*DATA_W-1:0]   fwd_wdata;
    logic [NSRC*DATA_W-1:0]   id_operand;
    logic                     id_ready_go;
    logic                     out_valid;
    logic                     out_allowin;
    logic [CNT_W-1:0]         stall_cnt;

    int total = 0;
    int bad   = 0;

    id_operand_stage #(
        .DATA_W(DATA_W), .RADDR_W(RADDR_W), .NSRC(NSRC), .NFWD(NFWD),
        .PAYLOAD_W(PAYLOAD_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .resetn(resetn),
        .in_valid(in_valid), .in_allowin(in_allowin), .in_payload(in_payload),
        .flush(flush), .id_payload(id_payload),
        .id_raddr(id_raddr), .id_ruse(id_ruse), .rf_rdata(rf_rdata),
        .fwd_valid(fwd_valid), .fwd_we(fwd_we), .fwd_waddr(fwd_waddr),
        .fwd_ready(fwd_ready), .fwd_wdata(fwd_wdata),
        .id_operand(id_operand), .id_ready_go(id_ready_go),
        .out_valid(out_valid), .out_allowin(out_allowin), .stall_cnt(stall_cnt)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- drivers ----------------
    // Advance one clock; inputs are changed and outputs sampled 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_fwd();
        fwd_valid = '0;
        fwd_we    = '0;
        fwd_waddr = '0;
        fwd_ready = '0;
        fwd_wdata = '0;
    endtask

    // Set one forwarding source f
    task automatic set_fwd(input int f, input logic [RADDR_W-1:0] waddr,
                           input logic rdy, input logic [DATA_W-1:0] data);
        fwd_valid[f]                     = 1'b1;
        fwd_we[f]                        = 1'b1;
        fwd_waddr[f*RADDR_W +: RADDR_W]  = waddr;
        fwd_ready[f]                     = rdy;
        fwd_wdata[f*DATA_W +: DATA_W]    = data;
    endtask

    task automatic set_src(input logic [RADDR_W-1:0] a0, input logic [RADDR_W-1:0] a1,
                           input logic [1:0] use_bits);
        id_raddr = {a1, a0};
        id_ruse  = use_bits;
    endtask

    localparam logic [63:0] P1 = 64'h0020_81B3_0000_1000;
    localparam logic [63:0] P2 = 64'h0002_0303_0000_1004;
    localparam logic [63:0] P6 = 64'h0000_0013_0000_2000;
    localparam logic [63:0] P7 = 64'hDEAD_BEEF_0000_2004;

    initial begin
        resetn      = 1'b0;
        in_valid    = 1'b0;
        in_payload  = '0;
        flush       = 1'b0;
        id_raddr    = '0;
        id_ruse     = '0;
        rf_rdata    = {32'h0000_BBBB, 32'h0000_AAAA};
        out_allowin = 1'b1;
        clear_fwd();

        // ---- 1. reset state, then a plain instruction ----
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_allowin", in_allowin, 1);
        chk("rst_stall_cnt", stall_cnt, 0);
        chk("rst_payload", id_payload, 0);
        @(negedge clk);
        resetn = 1'b1;

        tick();
        in_valid   = 1'b1;
        in_payload = P1;
        set_src(5'd1, 5'd2, 2'b11);
        tick();
        in_valid = 1'b0;
        settle();
        chk("t1_out_valid", out_valid, 1);
        chk("t1_payload", id_payload, P1);
        chk("t1_op0_rf", id_operand[31:0], 32'h0000_AAAA);
        chk("t1_op1_rf", id_operand[63:32], 32'h0000_BBBB);

        // ---- 2. youngest match wins (instruction still held, outputs combinational) ----
        set_fwd(0, 5'd1, 1'b1, 32'h11);
        set_fwd(2, 5'd1, 1'b1, 32'h22);
        settle();
        chk("t2_op0_youngest", id_operand[31:0], 32'h11);
        chk("t2_ready_go", id_ready_go, 1);
        clear_fwd();
        set_fwd(2, 5'd1, 1'b1, 32'h22);
        set_fwd(1, 5'd2, 1'b1, 32'h33);
        settle();
        chk("t2_op0_wb_only", id_operand[31:0], 32'h22);
        chk("t2_op1_mem", id_operand[63:32], 32'h33);
        clear_fwd();

        // ---- 3. load-use stall for one cycle ----
        in_valid   = 1'b1;
        in_payload = P2;
        tick();                     // P1 leaves, P2 enters
        in_valid = 1'b0;
        set_src(5'd4, 5'd5, 2'b11);
        set_fwd(0, 5'd4, 1'b0, 32'h0);
        set_fwd(2, 5'd4, 1'b1, 32'h99);     // older, stale value
        settle();
        chk("t3_ready_go", id_ready_go, 0);
        chk("t3_out_valid", out_valid, 0);
        chk("t3_in_allowin", in_allowin, 0);
        chk("t3_cnt_before", stall_cnt, 0);
        tick();
        clear_fwd();
        set_fwd(1, 5'd4, 1'b1, 32'h44);     // the load has moved to MEM
        settle();
        chk("t3_cnt_one", stall_cnt, 1);
        chk("t3_op0_mem", id_operand[31:0], 32'h44);
        chk("t3_op1_rf", id_operand[63:32], 32'h0000_BBBB);
        chk("t3_out_valid_go", out_valid, 1);
        tick();                     // P2 leaves
        chk("t3_empty", out_valid, 0);
        chk("t3_cnt_hold", stall_cnt, 1);
        clear_fwd();

        // ---- 4. r0 is always zero; an unused source never stalls ----
        in_valid   = 1'b1;
        in_payload = P1;
        tick();
        in_valid = 1'b0;
        set_src(5'd0, 5'd6, 2'b01);
        set_fwd(0, 5'd0, 1'b0, 32'hFF);
        set_fwd(1, 5'd6, 1'b0, 32'h66);
        settle();
        chk("t4_op0_zero", id_operand[31:0], 32'h0);
        chk("t4_op1_unused", id_operand[63:32], 32'h0000_BBBB);
        chk("t4_ready_go", id_ready_go, 1);
        clear_fwd();

        // ---- 5. flush with an incoming instruction, then flush during a stall ----
        out_allowin = 1'b0;         // keep the t4 instruction held
        in_valid    = 1'b1;
        in_payload  = P2;
        flush       = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        settle();
        chk("t5_flush_valid", out_valid, 0);
        chk("t5_flush_allowin", in_allowin, 1);
        tick();
        chk("t5_flush_stays", out_valid, 0);
        out_allowin = 1'b1;

        in_valid   = 1'b1;
        in_payload = P2;
        set_src(5'd4, 5'd5, 2'b11);
        set_fwd(0, 5'd4, 1'b0, 32'h0);
        tick();
        in_valid = 1'b0;
        settle();
        chk("t5_stall_go", id_ready_go, 0);
        tick();
        chk("t5_cnt_two", stall_cnt, 2);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t5_cnt_flush", stall_cnt, 2);
        chk("t5_dropped", in_allowin, 1);
        tick();
        chk("t5_cnt_after", stall_cnt, 2);
        chk("t5_out_valid", out_valid, 0);
        clear_fwd();

        // ---- 6. back-pressure from EXE is not a RAW stall ----
        set_src(5'd1, 5'd2, 2'b11);
        in_valid    = 1'b1;
        in_payload  = P6;
        out_allowin = 1'b0;
        tick();
        in_payload = P7;            // still offered, must not be taken
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("t6_in_allowin", in_allowin, 0);
            chk("t6_payload", id_payload, P6);
            chk("t6_out_valid", out_valid, 1);
            tick();
        end
        chk("t6_cnt", stall_cnt, 2);
        in_valid    = 1'b0;
        out_allowin = 1'b1;
        tick();
        chk("t6_drained", out_valid, 0);
        chk("t6_payload_kept", id_payload, P6);

        // ---- asynchronous reset in the middle of a stall ----
        in_valid   = 1'b1;
        in_payload = P2;
        set_src(5'd4, 5'd5, 2'b11);
        set_fwd(0, 5'd4, 1'b0, 32'h0);
        tick();
        in_valid = 1'b0;
        tick();
        chk("ar_cnt_pre", stall_cnt, 3);
        #2;
        resetn = 1'b0;
        #1;
        chk("ar_allowin", in_allowin, 1);
        chk("ar_cnt", stall_cnt, 0);
        chk("ar_payload", id_payload, 0);
        @(negedge clk);
        resetn = 1'b1;

        // ---- stall counter saturation (3-bit counter) ----
        in_valid   = 1'b1;
        in_payload = P2;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk("sat_cnt", stall_cnt, 7);
        chk("sat_still_stalled", out_valid, 0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        clear_fwd();
        tick();
        chk("sat_cnt_hold", stall_cnt, 7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time limit so the run always ends
    initial begin
        #100000;
        bad++;
        $display("FAIL timeout: got=running expected=finished");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
